sp_ram_fifo_ctrl: RTL and testbench

//   Initiator/controller end of the single-port RAM interface: sync FIFO control

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sp_ram_fifo_ctrl_if.sv | 31 +++
 rtl/sync_fifo_obuf.sv | 59 +++++
 rtl/sp_ram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_sp_ram_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller.
//   OP_IDLE/OP_WR/OP_RD : encoding of the one RAM operation chosen each cycle
//   cnt_width()         : width of the occupancy count for a given RAM depth
package sync_fifo_pkg;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;

    // Holds 0..DEPTH+2 (RAM + in-flight read + 2-entry output buffer), plus a spare bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return int'($clog2(depth + 2)) + 1;
    endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl_if.sv
// Push/pop stream bundle of the FIFO controller.
//   in_valid/in_ready/in_data     : push side
//   out_valid/out_ready/out_data  : show-ahead pop side
//   count                         : total entries held by the FIFO
// master = the user of the FIFO, slave = the FIFO controller.
interface sp_ram_fifo_ctrl_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/sync_fifo_obuf.sv
// Two-entry show-ahead buffer between the RAM read port and the FIFO output.
//   clk, rst         : clock, synchronous active-high reset
//   wr_en, wr_data   : write port (RAM read data returning)
//   rd_valid/rd_ready/rd_data : pop port, rd_data is the head entry
//   fill             : entries held (0..2)
// rd_data keeps its last value once the buffer drains.
module sync_fifo_obuf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       fill
);
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             head_vld;
    logic             tail_vld;
    logic             pop;

    assign pop = head_vld && rd_ready;

    // Head register feeds the output directly; tail only fills when head is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            head_vld <= 1'b0;
            tail_vld <= 1'b0;
        end else if (pop) begin
            if (tail_vld) begin
                head_q   <= tail_q;
                tail_q   <= wr_data;
                tail_vld <= wr_en;
            end else begin
                if (wr_en) begin
                    head_q <= wr_data;
                end
                head_vld <= wr_en;
            end
        end else if (wr_en) begin
            if (!head_vld) begin
                head_q   <= wr_data;
                head_vld <= 1'b1;
            end else begin
                tail_q   <= wr_data;
                tail_vld <= 1'b1;
            end
        end
    end

    assign rd_valid = head_vld;
    assign rd_data  = head_q;
    assign fill     = {1'b0, head_vld} + {1'b0, tail_vld};
endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external single-port RAM.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : push / show-ahead pop stream and occupancy count (slave side)
//   ram_cs, ram_wr, ram_addr, ram_wdata : RAM command, one op per cycle
//   ram_rdata  : RAM read data, valid the cycle after a read edge
// Prefetch reads win the RAM port over pushes, so streaming runs at one push per two cycles.
module sp_ram_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    sp_ram_fifo_ctrl_if.slave bus,
    output logic             ram_cs,
    output logic             ram_wr,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);
    localparam int unsigned CW  = cnt_width(DEPTH);
    localparam int unsigned RCW = $clog2(DEPTH + 1);

    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [RCW-1:0] ram_cnt;
    logic           rd_inflight;
    logic [CW-1:0]  count_q;
    logic [1:0]     obuf_cnt;
    logic           obuf_valid;
    logic           read_req;
    logic           push;
    logic           pop;
    logic [1:0]     op;

    // Prefetch whenever the RAM holds data and the buffer has room for one more return.
    assign read_req     = (ram_cnt != '0) && ((obuf_cnt + 2'(rd_inflight)) < 2'd2);
    assign bus.in_ready = !rst && (ram_cnt < RCW'(DEPTH)) && !read_req;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    // Single-port arbitration.
    always_comb begin
        op = OP_IDLE;
        if (rst) begin
            op = OP_IDLE;
        end else if (read_req) begin
            op = OP_RD;
        end else if (push) begin
            op = OP_WR;
        end
    end

    assign ram_cs    = (op != OP_IDLE);
    assign ram_wr    = (op == OP_WR);
    assign ram_addr  = (op == OP_WR) ? wptr : rptr;
    assign ram_wdata = bus.in_data;

    // Pointers, RAM occupancy and the read-in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= (op == OP_RD);
            if (op == OP_WR) begin
                wptr    <= wptr + AW'(1);
                ram_cnt <= ram_cnt + RCW'(1);
            end else if (op == OP_RD) begin
                rptr    <= rptr + AW'(1);
                ram_cnt <= ram_cnt - RCW'(1);
            end
        end
    end

    // Total occupancy, tracked at the stream boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (push && !pop) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Read data is only captured when a read was issued outside reset.
    sync_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rd_inflight),
        .wr_data  (ram_rdata),
        .rd_valid (obuf_valid),
        .rd_ready (bus.out_ready),
        .rd_data  (bus.out_data),
        .fill     (obuf_cnt)
    );

    assign bus.out_valid = obuf_valid && !rst;
    assign bus.count     = rst ? '0 : count_q;
endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed bench for sp_ram_fifo_ctrl with a behavioural single-port RAM (WIDTH=8, DEPTH=8).
module tb_sp_ram_fifo_ctrl;
    logic       clk;
    logic       rst;
    logic       ram_cs;
    logic       ram_wr;
    logic [2:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] mem [8];

    int checks;
    int failures;

    sp_ram_fifo_ctrl_if #(.WIDTH(8), .DEPTH(8)) bus ();

    sp_ram_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_cs    (ram_cs),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // single_ram_model stand-in: registered read, write on cs&wr.
    always_ff @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wr) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
            checks++;
            if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
            checks++;
            if (ram_cs !== 1'b0) begin failures++; $display("FAIL reset_ram_cs got=%0b exp=0", ram_cs); end
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    // Called in the first cycle after reset release.
    task automatic test_single_push();
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        #1;
        checks++;
        if ({ram_cs, ram_wr, ram_addr} !== {1'b1, 1'b1, 3'd0}) begin
            failures++; $display("FAIL e0_write cs/wr/addr got=%0b/%0b/%0d exp=1/1/0", ram_cs, ram_wr, ram_addr);
        end
        tick();                       // E0
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({ram_cs, ram_wr, ram_addr} !== {1'b1, 1'b0, 3'd0}) begin
            failures++; $display("FAIL e1_read cs/wr/addr got=%0b/%0b/%0d exp=1/0/0", ram_cs, ram_wr, ram_addr);
        end
        tick();                       // E1
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL early_out_valid got=%0b exp=0", bus.out_valid); end
        tick();                       // E2
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hA5}) begin
            failures++; $display("FAIL e2_head valid/data got=%0b/%h exp=1/a5", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.count} !== {1'b0, 8'hA5, 5'd0}) begin
            failures++; $display("FAIL empty_hold valid/data/count got=%0b/%h/%0d exp=0/a5/0", bus.out_valid, bus.out_data, bus.count);
        end
    endtask

    task automatic test_fill_and_drain();
        int idx;
        int exp;
        int cyc;
        idx = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = (idx < 12);
            bus.in_data  = 8'(idx);
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (idx !== 10) begin failures++; $display("FAIL fill_accepted got=%0d exp=10", idx); end
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
        checks++;
        if (bus.count !== 5'd10) begin failures++; $display("FAIL full_count got=%0d exp=10", bus.count); end
        exp = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        while (exp < 10 && cyc < 60) begin
            #1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== 8'(exp)) begin
                    failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", exp, bus.out_data, 8'(exp));
                end
                exp++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (exp !== 10) begin failures++; $display("FAIL drain_timeout popped=%0d exp=10", exp); end
        checks++;
        if ({bus.count, bus.out_valid} !== {5'd0, 1'b0}) begin
            failures++; $display("FAIL drain_end count/valid got=%0d/%0b exp=0/0", bus.count, bus.out_valid);
        end
    endtask

    // Pointers start at 11 mod 8 = 3 after the previous tests.
    task automatic test_stream();
        int sent;
        int recv;
        int rds;
        int cyc;
        int last_acc;
        logic [2:0] ea;
        sent = 0; recv = 0; rds = 0; cyc = 0; last_acc = 0;
        bus.out_ready = 1'b1;
        while (recv < 20 && cyc < 100) begin
            bus.in_valid = (sent < 20);
            bus.in_data  = 8'(8'h40 + sent);
            #1;
            if (ram_cs) begin
                ea = ram_wr ? 3'(3 + sent) : 3'(3 + rds);
                checks++;
                if (ram_addr !== ea) begin
                    failures++; $display("FAIL stream_addr wr=%0b got=%0d exp=%0d", ram_wr, ram_addr, ea);
                end
                if (!ram_wr) rds++;
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== 8'(8'h40 + recv)) begin
                    failures++; $display("FAIL stream_data idx=%0d got=%h exp=%h", recv, bus.out_data, 8'(8'h40 + recv));
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                last_acc = cyc + 1;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (recv !== 20) begin failures++; $display("FAIL stream_received got=%0d exp=20", recv); end
        checks++;
        if (sent !== 20 || last_acc > 42) begin
            failures++; $display("FAIL stream_throughput sent=%0d last_cycle=%0d exp=20 within 42", sent, last_acc);
        end
    endtask

    // wptr is at 31 mod 8 = 7: first push lands at 7, the deferred one at 0.
    task automatic test_read_priority();
        int cyc;
        bus.in_valid = 1'b1; bus.in_data = 8'h11;
        tick();
        bus.in_data = 8'h22;
        #1;
        checks++;
        if ({bus.in_ready, ram_cs, ram_wr, ram_addr} !== {1'b0, 1'b1, 1'b0, 3'd7}) begin
            failures++; $display("FAIL rdprio_blocked rdy/cs/wr/addr got=%0b/%0b/%0b/%0d exp=0/1/0/7", bus.in_ready, ram_cs, ram_wr, ram_addr);
        end
        tick();
        #1;
        checks++;
        if (bus.count !== 5'd1) begin failures++; $display("FAIL rdprio_not_taken count got=%0d exp=1", bus.count); end
        checks++;
        if ({bus.in_ready, ram_wr, ram_addr} !== {1'b1, 1'b1, 3'd0}) begin
            failures++; $display("FAIL rdprio_retry rdy/wr/addr got=%0b/%0b/%0d exp=1/1/0", bus.in_ready, ram_wr, ram_addr);
        end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd2) begin failures++; $display("FAIL rdprio_count got=%0d exp=2", bus.count); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc = 0;
            while (!bus.out_valid && cyc < 10) begin tick(); #1; cyc++; end
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, (k == 0) ? 8'h11 : 8'h22}) begin
                failures++; $display("FAIL rdprio_pop%0d valid/data got=%0b/%h", k, bus.out_valid, bus.out_data);
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_inflight();
        int cyc;
        #1;
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        tick();                       // E0: push
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({ram_cs, ram_wr} !== 2'b10) begin failures++; $display("FAIL rstrd_read_issue cs/wr got=%0b/%0b exp=1/0", ram_cs, ram_wr); end
        tick();                       // E1: read issued
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, ram_cs, bus.count, bus.out_valid} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
            failures++; $display("FAIL rstrd_during rdy/cs/count/valid got=%0b/%0b/%0d/%0b exp=0/0/0/0", bus.in_ready, ram_cs, bus.count, bus.out_valid);
        end
        tick();                       // E2: reset edge, rdata returning
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.count, bus.out_valid} !== {5'd0, 1'b0}) begin
                failures++; $display("FAIL rstrd_discard cyc%0d count/valid got=%0d/%0b exp=0/0", k, bus.count, bus.out_valid);
            end
            tick();
        end
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        #1;
        checks++;
        if ({ram_wr, ram_addr} !== {1'b1, 3'd0}) begin failures++; $display("FAIL rstrd_ptr wr/addr got=%0b/%0d exp=1/0", ram_wr, ram_addr); end
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        #1;
        while (!bus.out_valid && cyc < 10) begin tick(); #1; cyc++; end
        checks++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h3C}) begin
            failures++; $display("FAIL rstrd_push valid/data got=%0b/%h exp=1/3c", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0) begin failures++; $display("FAIL rstrd_final_count got=%0d exp=0", bus.count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_push();
        tick();
        test_fill_and_drain();
        tick();
        test_stream();
        tick();
        test_read_priority();
        tick();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
